// File: rtl/gfx256_pixel_reader_if.sv
// Request, pixel-output and 256-bit memory-read signals of the pixel reader.
// slave: the reader's view; master: the requester/bus-model view.
interface gfx256_pixel_reader_if #(parameter int ADDR_W = 32);
  logic [1:0]        color_depth_i;
  logic              invalidate_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic              pix_valid_o;
  logic              pix_ready_i;
  logic [31:0]       pix_color_o;
  logic              mem_cyc_o;
  logic              mem_stb_o;
  logic              mem_we_o;
  logic [31:0]       mem_sel_o;
  logic [ADDR_W-1:0] mem_adr_o;
  logic              mem_ack_i;
  logic [255:0]      mem_dat_i;

  modport slave (
    input  color_depth_i, invalidate_i, req_valid_i, req_addr_i, pix_ready_i,
           mem_ack_i, mem_dat_i,
    output req_ready_o, pix_valid_o, pix_color_o,
           mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o, mem_adr_o
  );

  modport master (
    output color_depth_i, invalidate_i, req_valid_i, req_addr_i, pix_ready_i,
           mem_ack_i, mem_dat_i,
    input  req_ready_o, pix_valid_o, pix_color_o,
           mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o, mem_adr_o
  );
endinterface

// File: rtl/gfx256_pixel_reader.sv
// Pixel fetch unit: one-line 256-bit buffer, Wishbone-style line fetch on miss,
// color extraction at 8/16/24/32 bpp into a valid/ready output register.
module gfx256_pixel_reader #(
  parameter int ADDR_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  gfx256_pixel_reader_if.slave  bus
);
  typedef enum logic {IDLE, FETCH} state_e;

  state_e            state_q, state_d;
  logic [255:0]      line_q, line_d;
  logic [ADDR_W-6:0] tag_q, tag_d;
  logic              line_vld_q, line_vld_d;
  logic              inv_seen_q, inv_seen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        depth_q, depth_d;
  logic              pix_valid_q, pix_valid_d;
  logic [31:0]       pix_color_q, pix_color_d;
  logic              req_ready, accept, hit;

  // Bytes shifted in from above bit 255 are zero, so a pixel straddling the
  // end of the line is simply truncated.
  function automatic logic [31:0] extract(input logic [255:0] line,
                                          input logic [4:0]   ofs,
                                          input logic [1:0]   depth);
    logic [31:0] mask;
    case (depth)
      2'd0:    mask = 32'h0000_00FF;
      2'd1:    mask = 32'h0000_FFFF;
      2'd2:    mask = 32'h00FF_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return 32'(line >> {ofs, 3'b000}) & mask;
  endfunction

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    tag_d       = tag_q;
    line_vld_d  = line_vld_q;
    inv_seen_d  = inv_seen_q;
    addr_d      = addr_q;
    depth_d     = depth_q;
    pix_valid_d = pix_valid_q && !bus.pix_ready_i;
    pix_color_d = pix_color_q;

    req_ready = !rst_i && (state_q == IDLE) && (!pix_valid_q || bus.pix_ready_i);
    accept    = req_ready && bus.req_valid_i;
    hit       = line_vld_q && (tag_q == bus.req_addr_i[ADDR_W-1:5]) && !bus.invalidate_i;

    case (state_q)
      IDLE: begin
        if (bus.invalidate_i) line_vld_d = 1'b0;
        if (accept) begin
          addr_d  = bus.req_addr_i;
          depth_d = bus.color_depth_i;
          if (hit) begin
            pix_valid_d = 1'b1;
            pix_color_d = extract(line_q, bus.req_addr_i[4:0], bus.color_depth_i);
          end else begin
            state_d    = FETCH;
            inv_seen_d = 1'b0;
          end
        end
      end
      FETCH: begin
        if (bus.invalidate_i) inv_seen_d = 1'b1;
        if (bus.mem_ack_i) begin
          line_d      = bus.mem_dat_i;
          tag_d       = addr_q[ADDR_W-1:5];
          // A line that was invalidated while in flight may already be stale.
          line_vld_d  = !(bus.invalidate_i || inv_seen_q);
          pix_valid_d = 1'b1;
          pix_color_d = extract(bus.mem_dat_i, addr_q[4:0], depth_q);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      line_q      <= '0;
      tag_q       <= '0;
      line_vld_q  <= 1'b0;
      inv_seen_q  <= 1'b0;
      addr_q      <= '0;
      depth_q     <= '0;
      pix_valid_q <= 1'b0;
      pix_color_q <= '0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      tag_q       <= tag_d;
      line_vld_q  <= line_vld_d;
      inv_seen_q  <= inv_seen_d;
      addr_q      <= addr_d;
      depth_q     <= depth_d;
      pix_valid_q <= pix_valid_d;
      pix_color_q <= pix_color_d;
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.pix_valid_o = pix_valid_q;
  assign bus.pix_color_o = pix_color_q;
  assign bus.mem_cyc_o   = (state_q == FETCH);
  assign bus.mem_stb_o   = (state_q == FETCH);
  assign bus.mem_we_o    = 1'b0;
  assign bus.mem_sel_o   = (state_q == FETCH) ? 32'hFFFF_FFFF : 32'h0;
  assign bus.mem_adr_o   = (state_q == FETCH) ? {addr_q[ADDR_W-1:5], 5'b0} : '0;
endmodule

// File: tb/tb_gfx256_pixel_reader.sv
// Directed bench for gfx256_pixel_reader: miss/hit, depth edges, backpressure,
// invalidation and reset during a fetch.
module tb_gfx256_pixel_reader;
  logic clk, rst;
  int   total = 0;
  int   bad   = 0;

  gfx256_pixel_reader_if #(.ADDR_W(32)) bif();

  gfx256_pixel_reader #(.ADDR_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Line 0x100: byte i = 0x10+i except bytes 4..7 = EF BE AD DE.
  // Every other line: byte i = 0x80+i.
  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 32; i++)
      l[i*8 +: 8] = (a == 32'h100) ? 8'(8'h10 + i) : 8'(8'h80 + i);
    if (a == 32'h100) begin
      l[39:32] = 8'hEF;
      l[47:40] = 8'hBE;
      l[55:48] = 8'hAD;
      l[63:56] = 8'hDE;
    end
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request and hold it until accepted (bounded); returns 1 ns after
  // the accepting edge with req_valid_i dropped.
  task automatic req(input logic [31:0] a, input logic [1:0] d, input string tag);
    int n = 0;
    bif.req_valid_i   = 1'b1;
    bif.req_addr_i    = a;
    bif.color_depth_i = d;
    #1;
    while (!bif.req_ready_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_accept"}, {31'b0, bif.req_ready_o}, 32'h1);
    @(posedge clk); #1;
    bif.req_valid_i = 1'b0;
  endtask

  // Memory model: waits, then acks one cycle with the addressed line.
  task automatic serve(input int waits);
    repeat (waits) begin @(posedge clk); #1; end
    bif.mem_dat_i = line_of(bif.mem_adr_o);
    bif.mem_ack_i = 1'b1;
    @(posedge clk); #1;
    bif.mem_ack_i = 1'b0;
  endtask

  task automatic hit_chk(input logic [31:0] a, input logic [1:0] d,
                         input logic [31:0] exp, input string tag);
    req(a, d, tag);
    @(negedge clk);
    chk({tag, "_valid"}, {31'b0, bif.pix_valid_o}, 32'h1);
    chk({tag, "_color"}, bif.pix_color_o, exp);
    chk({tag, "_nocyc"}, {31'b0, bif.mem_cyc_o}, 32'h0);
  endtask

  initial begin
    rst               = 1'b1;
    bif.color_depth_i = 2'd0;
    bif.invalidate_i  = 1'b0;
    bif.req_valid_i   = 1'b0;
    bif.req_addr_i    = '0;
    bif.pix_ready_i   = 1'b1;
    bif.mem_ack_i     = 1'b0;
    bif.mem_dat_i     = '0;

    // Reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", {31'b0, bif.req_ready_o}, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {31'b0, bif.pix_valid_o}, 32'h0);
    chk("post_rst_cyc",   {31'b0, bif.mem_cyc_o},   32'h0);
    chk("post_rst_sel",   bif.mem_sel_o,            32'h0);
    chk("post_rst_ready", {31'b0, bif.req_ready_o}, 32'h1);

    // Miss at 0x104, depth 3, two wait cycles
    req(32'h104, 2'd3, "miss");
    @(negedge clk);
    chk("miss_cyc",   {31'b0, bif.mem_cyc_o}, 32'h1);
    chk("miss_stb",   {31'b0, bif.mem_stb_o}, 32'h1);
    chk("miss_adr",   bif.mem_adr_o,          32'h100);
    chk("miss_sel",   bif.mem_sel_o,          32'hFFFF_FFFF);
    chk("miss_we",    {31'b0, bif.mem_we_o},  32'h0);
    chk("miss_early", {31'b0, bif.pix_valid_o}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("miss_adr_hold", bif.mem_adr_o, 32'h100);
    serve(1);
    @(negedge clk);
    chk("miss_valid", {31'b0, bif.pix_valid_o}, 32'h1);
    chk("miss_color", bif.pix_color_o,          32'hDEAD_BEEF);
    chk("miss_drop",  {31'b0, bif.mem_cyc_o},   32'h0);

    // Same-line hit, then output clears after handshake
    hit_chk(32'h108, 2'd3, 32'h1B1A_1918, "hit");
    @(posedge clk); #1;
    @(negedge clk);
    chk("hit_clear", {31'b0, bif.pix_valid_o}, 32'h0);

    // Depth edges within line 0x100
    hit_chk(32'h11F, 2'd0, 32'h0000_002F, "d0_edge");
    hit_chk(32'h11E, 2'd2, 32'h0000_2F2E, "d2_edge");
    hit_chk(32'h102, 2'd1, 32'h0000_1312, "d1_mid");

    // Backpressure: output stalls 5 cycles with a request waiting
    @(posedge clk); #1;
    bif.pix_ready_i = 1'b0;
    req(32'h100, 2'd3, "bp_first");
    bif.req_valid_i   = 1'b1;
    bif.req_addr_i    = 32'h101;
    bif.color_depth_i = 2'd0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_color", bif.pix_color_o,          32'h1312_1110);
      chk("bp_valid", {31'b0, bif.pix_valid_o}, 32'h1);
      chk("bp_ready", {31'b0, bif.req_ready_o}, 32'h0);
      @(posedge clk); #1;
    end
    bif.pix_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'b0, bif.req_ready_o}, 32'h1);
    @(posedge clk); #1;
    bif.req_valid_i = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", {31'b0, bif.pix_valid_o}, 32'h1);
    chk("bp_next_color", bif.pix_color_o,          32'h0000_0011);

    // Invalidate during FETCH of line 0x200
    req(32'h200, 2'd3, "inv_fetch");
    @(negedge clk);
    chk("inv_fetch_adr", bif.mem_adr_o, 32'h200);
    @(posedge clk); #1;
    bif.invalidate_i = 1'b1;
    @(posedge clk); #1;
    bif.invalidate_i = 1'b0;
    serve(0);
    @(negedge clk);
    chk("inv_fetch_color", bif.pix_color_o, 32'h8382_8180);
    req(32'h204, 2'd3, "inv_refetch");
    @(negedge clk);
    chk("inv_refetch_cyc", {31'b0, bif.mem_cyc_o}, 32'h1);
    chk("inv_refetch_adr", bif.mem_adr_o,          32'h200);
    serve(0);
    @(negedge clk);
    chk("inv_refetch_color", bif.pix_color_o, 32'h8786_8584);
    hit_chk(32'h208, 2'd3, 32'h8B8A_8988, "inv_then_hit");

    // Invalidate while idle, then same-line request refetches
    @(posedge clk); #1;
    bif.invalidate_i = 1'b1;
    @(posedge clk); #1;
    bif.invalidate_i = 1'b0;
    req(32'h20C, 2'd3, "idle_inv");
    @(negedge clk);
    chk("idle_inv_cyc", {31'b0, bif.mem_cyc_o}, 32'h1);
    serve(0);
    @(negedge clk);
    chk("idle_inv_color", bif.pix_color_o, 32'h8F8E_8D8C);

    // Reset during FETCH, ack arrives one cycle after the reset edge
    req(32'h300, 2'd3, "rst_fetch");
    @(negedge clk);
    chk("rst_fetch_cyc", {31'b0, bif.mem_cyc_o}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_fetch_ready", {31'b0, bif.req_ready_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bif.mem_dat_i = line_of(32'h300);
    bif.mem_ack_i = 1'b1;
    @(negedge clk);
    chk("rst_fetch_drop",  {31'b0, bif.mem_cyc_o},   32'h0);
    chk("rst_fetch_noval", {31'b0, bif.pix_valid_o}, 32'h0);
    @(posedge clk); #1;
    bif.mem_ack_i = 1'b0;
    @(negedge clk);
    chk("rst_late_ack", {31'b0, bif.pix_valid_o}, 32'h0);
    req(32'h304, 2'd3, "rst_after");
    @(negedge clk);
    chk("rst_after_miss", {31'b0, bif.mem_cyc_o}, 32'h1);
    serve(0);
    @(negedge clk);
    chk("rst_after_color", bif.pix_color_o, 32'h8786_8584);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
